mac_operand_seq: RTL
====================

# mac_operand_seq

Parametrised, registered successor to the MAC operand multiplexer in the FFT datapath. It selects one complex operand vector from `NUM_SRC` source register banks and holds it in an output register behind a valid/ready handshake. It either issues a single vector or sweeps automatically through a contiguous, wrapping range of sources, one vector per accepted handshake. It sits between the register banks (x, A, B, C, D, ...) and the MAC array input.

## Interface
- `DATA_W`, default 16: bits per real or imaginary component.
- `VEC_LEN`, default 16: complex elements per vector; vector width `VW = 2*VEC_LEN*DATA_W`.
- `NUM_SRC`, default 5: number of source banks (≥2).
- `SEL_W`, default 3: select width, with `2**SEL_W ≥ NUM_SRC`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: begin a transfer. Accepted only when `busy`=0.
- `mode`  in  1: 0 = single vector, 1 = sweep.
- `sel_first`  in  SEL_W: first source index; sampled on start.
- `sel_last`  in  SEL_W: last source index; sampled on start and used only when `mode`=1.
- `src_vecs`  in  NUM_SRC*VW: source banks concatenated; bank k occupies bits `[k*VW +: VW]`.
- `out_vec`  out  VW: registered operand vector.
- `out_sel`  out  SEL_W: index of the bank held in `out_vec`.
- `out_valid`  out  1: `out_vec` is valid.
- `out_ready`  in  1: consumer accepts `out_vec` when `out_valid`=1 and `out_ready`=1.
- `out_last`  out  1: the held vector is the final one of the transfer.
- `busy`  out  1: a transfer is in progress.
- `done`  out  1: one-cycle pulse after the final handshake.

## Operation
- Index normalisation at start: any `sel_first` or `sel_last` ≥ NUM_SRC is clamped to NUM_SRC-1.
- Transfer length:
  - `mode`=0: 1.
  - `mode`=1: `((last - first) mod NUM_SRC) + 1`, in the range 1..NUM_SRC. If last < first, the sweep wraps from NUM_SRC-1 to 0. If first = last, length is 1.
- States: IDLE, RUN, FLUSH.
  - IDLE: `busy`=0. On `start`:
    - capture first, last and mode;
    - load `out_vec` ← bank[first] and `out_sel` ← first;
    - `out_valid` ← 1; `out_last` ← (length==1);
    - next state is RUN if length>1, else FLUSH.
  - RUN: on handshake, load bank[cur+1 wrapped], update `out_sel`, and hold `out_valid`=1. When the loaded index equals last, set `out_last` ← 1 and go to FLUSH.
  - FLUSH: on handshake, `out_valid` ← 0, `out_last` ← 0, pulse `done`, go to IDLE.
- Data is captured at load time. Later changes on `src_vecs` do not alter a held `out_vec`.
- While `out_valid`=1 and `out_ready`=0, `out_vec`, `out_sel` and `out_last` hold stable.
- `start` while `busy`=1 is ignored and has no side effects.
- `busy`=1 in RUN and FLUSH.
- In IDLE, `out_vec` keeps its last value. `out_valid`=0 there.

## Timing
- Reset values: `out_vec`=0, `out_sel`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE.
- Reset during a transfer aborts it immediately. No `done` is produced.
- Latency: `start` sampled at edge t → `out_valid`=1 and `busy`=1 after edge t.
- Throughput: with `out_ready` held at 1, one new vector per cycle. A length-L sweep finishes in L cycles after start.
- `done`=1 for exactly the cycle after the final-handshake edge. `busy`=0 in that same cycle.
- A `start` in the `done` cycle is accepted; back-to-back transfers have no bubble beyond the `done` cycle.
- `out_valid` never drops without a handshake, except on reset.

## Test plan
- Reset then idle: assert `rst` mid-cycle (asynchronous) → all outputs 0 immediately. `start`=0 for 10 cycles → outputs unchanged.
- Single mode: NUM_SRC=5, bank k = vector filled with 16'h1000+k. Drive `start`, `mode`=0, `sel_first`=2, `out_ready`=1 → one cycle later `out_vec`=bank2, `out_sel`=2, `out_last`=1. The following cycle has `done`=1, `busy`=0.
- Sweep with wrap: `mode`=1, first=3, last=1, `out_ready`=1 → `out_sel` sequence 3,4,0,1 on consecutive cycles. `out_last` is 1 only with 1. `done` comes 4 cycles after start.
- Backpressure: sweep 0→2 with `out_ready` low for 3 cycles on the second vector → `out_vec`=bank1 held stable throughout. No index is skipped. `src_vecs` changes during the stall do not affect `out_vec`.
- Clamp and ignore: first=7 → treated as 4 (single → bank4). A second `start` while `busy`=1 has no effect on the sequence.
- Reset mid-sweep: `rst` asserted after the second vector of a 0→4 sweep → `out_valid`=0, `busy`=0, no `done`. A new start with first=1 works normally.

Source files
------------

// File: rtl/mac_operand_seq.sv
// Registered MAC operand sequencer: selects one complex vector from NUM_SRC banks and
// issues it singly or as a wrapping sweep, one vector per valid/ready handshake.
module mac_operand_seq #(
    parameter int DATA_W  = 16,
    parameter int VEC_LEN = 16,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   mode,
    input  logic [SEL_W-1:0]                       sel_first,
    input  logic [SEL_W-1:0]                       sel_last,
    input  logic [NUM_SRC*2*VEC_LEN*DATA_W-1:0]    src_vecs,
    output logic [2*VEC_LEN*DATA_W-1:0]            out_vec,
    output logic [SEL_W-1:0]                       out_sel,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int VW = 2 * VEC_LEN * DATA_W;
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] last_q;

    logic [VW-1:0]    banks [NUM_SRC];
    logic [SEL_W-1:0] first_c;
    logic [SEL_W-1:0] last_c;
    logic [SEL_W-1:0] nxt_sel;
    logic             single;
    logic             hs;

    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        return (int'(s) >= NUM_SRC) ? MAX_SEL : s;
    endfunction

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
        return (s == MAX_SEL) ? '0 : s + 1'b1;
    endfunction

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_bank
        assign banks[k] = src_vecs[k*VW +: VW];
    end

    // Out-of-range requests are clamped so the bank lookup can never leave the array.
    assign first_c = clamp_sel(sel_first);
    assign last_c  = clamp_sel(sel_last);
    assign single  = !mode || (first_c == last_c);
    assign nxt_sel = wrap_inc(out_sel);
    assign hs      = out_valid && out_ready;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_q    <= '0;
            out_vec   <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_q    <= last_c;
                        out_vec   <= banks[first_c];
                        out_sel   <= first_c;
                        out_valid <= 1'b1;
                        out_last  <= single;
                        busy      <= 1'b1;
                        state     <= single ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        out_vec <= banks[nxt_sel];
                        out_sel <= nxt_sel;
                        if (nxt_sel == last_q) begin
                            out_last <= 1'b1;
                            state    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // out_vec is deliberately left holding the final vector.
                    if (hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
